// File: rtl/alu_pwr_pkg.sv
// alu_pwr_pkg: power-island state encoding, per-state output tables and counter sizing helper
package alu_pwr_pkg;
  typedef enum logic [2:0] {
    OFF     = 3'd0,
    PWR_UP  = 3'd1,
    RST_REL = 3'd2,
    ON      = 3'd3,
    DRAIN   = 3'd4,
    ISO     = 3'd5
  } pwr_state_e;
  // Bit n holds the output value for state n; unused encodings 6/7 mirror OFF.
  localparam logic [7:0] PWR_EN_TBL = 8'b0011_1110;
  localparam logic [7:0] ISO_EN_TBL = 8'b1110_0111;
  localparam logic [7:0] RST_N_TBL  = 8'b0011_1100;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/alu_pwr_seq.sv
// alu_pwr_seq: power sequencing FSM with a shared saturating dwell counter and sticky drain timeout flag
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int PWR_UP_CYCLES = 4,
  parameter int RST_CYCLES    = 2,
  parameter int DRAIN_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_req,
  input  logic       alu_busy,
  output pwr_state_e state,
  output logic       drain_err
);
  localparam int CMAX = max3(PWR_UP_CYCLES, RST_CYCLES, DRAIN_TIMEOUT);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PU_T  = CW'(PWR_UP_CYCLES - 1);
  localparam logic [CW-1:0] RS_T  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DT_T  = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] C_TOP = CW'(CMAX);
  localparam logic [CW-1:0] ONE   = CW'(1);
  pwr_state_e nxt;
  logic [CW-1:0] cnt;
  logic err_set;
  always_comb begin
    nxt = state;
    err_set = 1'b0;
    case (state)
      OFF:     nxt = pwr_req ? PWR_UP : OFF;
      PWR_UP:  nxt = !pwr_req ? OFF : (cnt == PU_T ? RST_REL : PWR_UP);
      RST_REL: nxt = !pwr_req ? OFF : (cnt == RS_T ? ON : RST_REL);
      ON:      nxt = pwr_req ? ON : DRAIN;
      DRAIN: begin
        // Re-request wins over both exits so an in-flight op is never isolated needlessly.
        if (pwr_req) nxt = ON;
        else if (!alu_busy) nxt = ISO;
        else if (cnt == DT_T) begin
          nxt = ISO;
          err_set = 1'b1;
        end
      end
      ISO:     nxt = OFF;
      default: nxt = OFF;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      cnt <= '0;
      drain_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : (cnt == C_TOP ? cnt : cnt + ONE);
      if (err_set) drain_err <= 1'b1;
    end
  end
endmodule

// File: rtl/alu_pwr_island.sv
// alu_pwr_island: gated-ALU power island controller with start gating and isolation-safe registered result
// Optional ALU_PWR_RETENTION_EN: isolated result shows the value retained at ISO entry instead of CLAMP_VALUE.
module alu_pwr_island
  import alu_pwr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW = 4,
  parameter int PWR_UP_CYCLES = 4,
  parameter int RST_CYCLES = 2,
  parameter int DRAIN_TIMEOUT = 32,
  parameter logic [WIDTH-1:0] CLAMP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwr_req,
  input  logic             start,
  output logic             start_ready,
  output logic             alu_start,
  output logic             alu_pwr_en,
  output logic             alu_iso_en,
  output logic             alu_rst_n,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_busy,
  output logic [WIDTH-1:0] result,
  output logic             pwr_ack,
  output logic [2:0]       pwr_state,
  output logic             drain_err
);
  pwr_state_e st;
  logic [WIDTH-1:0] iso_nxt;
  alu_pwr_seq #(
    .PWR_UP_CYCLES(PWR_UP_CYCLES),
    .RST_CYCLES(RST_CYCLES),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) u_seq (
    .clk(clk),
    .rst_n(rst_n),
    .pwr_req(pwr_req),
    .alu_busy(alu_busy),
    .state(st),
    .drain_err(drain_err)
  );
  assign pwr_state = st;
  assign start_ready = (st == ON);
  assign pwr_ack = start_ready;
  assign alu_start = start & start_ready;
  assign alu_pwr_en = PWR_EN_TBL[st];
  assign alu_iso_en = ISO_EN_TBL[st];
  assign alu_rst_n = RST_N_TBL[st];
`ifdef ALU_PWR_RETENTION_EN
  logic [WIDTH-1:0] ret;
  // ISO lasts one cycle: the last DRAIN sample is held there and copied into retention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ret <= CLAMP_VALUE;
    else if (st == ISO) ret <= result;
  end
  assign iso_nxt = (st == ISO) ? result : ret;
`else
  assign iso_nxt = CLAMP_VALUE;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result <= CLAMP_VALUE;
    else result <= (st == ON || st == DRAIN) ? alu_result : iso_nxt;
  end
endmodule

// File: tb/tb_alu_pwr_island.sv
// tb_alu_pwr_island: directed power-sequencing vectors with hand-computed expectations
module tb_alu_pwr_island;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n, pwr_req, start, alu_busy;
  logic [W-1:0] alu_result;
  logic start_ready, alu_start, alu_pwr_en, alu_iso_en, alu_rst_n, pwr_ack, drain_err;
  logic [W-1:0] result;
  logic [2:0] pwr_state;
  int errors = 0;
  int checks = 0;
`ifdef ALU_PWR_RETENTION_EN
  localparam logic [W-1:0] ISO_A = 16'h5678;
  localparam logic [W-1:0] ISO_B = 16'hBEEF;
`else
  localparam logic [W-1:0] ISO_A = 16'h0000;
  localparam logic [W-1:0] ISO_B = 16'h0000;
`endif
  alu_pwr_island dut (
    .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .start(start),
    .start_ready(start_ready), .alu_start(alu_start), .alu_pwr_en(alu_pwr_en),
    .alu_iso_en(alu_iso_en), .alu_rst_n(alu_rst_n), .alu_result(alu_result),
    .alu_busy(alu_busy), .result(result), .pwr_ack(pwr_ack),
    .pwr_state(pwr_state), .drain_err(drain_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_st(input string tag, input logic [2:0] s, input logic pe, input logic ie, input logic rn);
    chk({tag, ".state"}, 32'(pwr_state), 32'(s));
    chk({tag, ".pwr_en"}, 32'(alu_pwr_en), 32'(pe));
    chk({tag, ".iso_en"}, 32'(alu_iso_en), 32'(ie));
    chk({tag, ".rst_n"}, 32'(alu_rst_n), 32'(rn));
  endtask
  initial begin
    rst_n = 1'b0; pwr_req = 1'b0; start = 1'b0; alu_busy = 1'b0; alu_result = 16'hDEAD;
    step(2);
    chk_st("reset", 3'd0, 1'b0, 1'b1, 1'b0);
    chk("reset.result", 32'(result), 32'h0);
    chk("reset.ack", 32'(pwr_ack), 32'h0);
    chk("reset.err", 32'(drain_err), 32'h0);
    rst_n = 1'b1;
    step();
    chk_st("off_idle", 3'd0, 1'b0, 1'b1, 1'b0);
    // power-up sequence
    pwr_req = 1'b1;
    step();
    chk_st("pu1", 3'd1, 1'b1, 1'b1, 1'b0);
    step(3);
    chk_st("pu4", 3'd1, 1'b1, 1'b1, 1'b0);
    chk("pu4.result", 32'(result), 32'h0);
    step();
    chk_st("rr1", 3'd2, 1'b1, 1'b1, 1'b1);
    step();
    chk_st("rr2", 3'd2, 1'b1, 1'b1, 1'b1);
    chk("rr2.ack", 32'(pwr_ack), 32'h0);
    step();
    chk_st("on", 3'd3, 1'b1, 1'b0, 1'b1);
    chk("on.ack", 32'(pwr_ack), 32'h1);
    chk("on.result_unsampled", 32'(result), 32'h0);
    // ON: result latency and start gating
    alu_result = 16'h1234; start = 1'b1;
    #1 chk("on.alu_start", 32'(alu_start), 32'h1);
    step();
    chk("on.result", 32'(result), 32'h1234);
    // start accepted in the cycle pwr_req falls
    alu_busy = 1'b1; pwr_req = 1'b0;
    #1 chk("fall.alu_start", 32'(alu_start), 32'h1);
    step();
    chk_st("drain", 3'd4, 1'b1, 1'b0, 1'b1);
    #1 chk("drain.alu_start", 32'(alu_start), 32'h0);
    chk("drain.ready", 32'(start_ready), 32'h0);
    start = 1'b0; alu_result = 16'h5678;
    step(3);
    chk("drain.hold", 32'(pwr_state), 32'd4);
    chk("drain.result", 32'(result), 32'h5678);
    alu_busy = 1'b0;
    step();
    chk_st("iso", 3'd5, 1'b1, 1'b1, 1'b1);
    chk("iso.result", 32'(result), 32'h5678);
    alu_result = 16'h9999;
    step();
    chk_st("off", 3'd0, 1'b0, 1'b1, 1'b0);
    chk("off.result", 32'(result), 32'(ISO_A));
    chk("off.err", 32'(drain_err), 32'h0);
    // pwr_req drops in PWR_UP cycle 2
    pwr_req = 1'b1;
    step(2);
    chk("abort.pu2", 32'(pwr_state), 32'd1);
    pwr_req = 1'b0;
    step();
    chk_st("abort.off", 3'd0, 1'b0, 1'b1, 1'b0);
    // power up again, then re-raise during DRAIN
    pwr_req = 1'b1;
    step(7);
    chk("up2.state", 32'(pwr_state), 32'd3);
    chk("up2.result", 32'(result), 32'(ISO_A));
    alu_result = 16'hBEEF; alu_busy = 1'b1; pwr_req = 1'b0;
    step();
    chk_st("rd.drain", 3'd4, 1'b1, 1'b0, 1'b1);
    pwr_req = 1'b1;
    step();
    chk_st("rd.on", 3'd3, 1'b1, 1'b0, 1'b1);
    // DRAIN timeout with busy stuck
    pwr_req = 1'b0;
    step();
    chk("to.drain", 32'(pwr_state), 32'd4);
    step(31);
    chk("to.drain32", 32'(pwr_state), 32'd4);
    chk("to.err_pre", 32'(drain_err), 32'h0);
    step();
    chk_st("to.iso", 3'd5, 1'b1, 1'b1, 1'b1);
    chk("to.err", 32'(drain_err), 32'h1);
    chk("to.iso_result", 32'(result), 32'hBEEF);
    alu_busy = 1'b0;
    step();
    chk("to.off_result", 32'(result), 32'(ISO_B));
    pwr_req = 1'b1;
    step(7);
    chk("to.on_again", 32'(pwr_state), 32'd3);
    chk("to.err_sticky", 32'(drain_err), 32'h1);
    // async reset mid-ON
    alu_result = 16'h4321;
    step();
    chk("mid.result", 32'(result), 32'h4321);
    #2 rst_n = 1'b0;
    #1 chk_st("arst", 3'd0, 1'b0, 1'b1, 1'b0);
    chk("arst.result", 32'(result), 32'h0);
    chk("arst.err", 32'(drain_err), 32'h0);
    chk("arst.ack", 32'(pwr_ack), 32'h0);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
